// File: rtl/op_sequencer.sv
// Sign-magnitude add/subtract/multiply sequencer: one-cycle add/sub, 15-cycle shift-add multiply,
// saturating 16-bit result with overflow and invalid-opcode flags held until the next accepted start.
module op_sequencer (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        overflow,
    output logic        err
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDSUB = 2'd1,
        MUL    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [29:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        sign_b_eff_s;
    logic        addsub_sign_s;
    logic [15:0] addsub_mag_s;
    logic [29:0] partial_s;
    logic [29:0] acc_next_s;
    logic [16:0] addsub_pack_s;
    logic [16:0] mul_pack_s;

    // Packs {overflow, sign, magnitude}; zero magnitudes always come out as +0.
    function automatic logic [16:0] saturate(input logic sign, input logic [29:0] mag);
        logic [16:0] packed_v;
        if (mag == 30'd0) begin
            packed_v = 17'd0;
        end else if (mag > 30'd32767) begin
            packed_v = {1'b1, sign, 15'h7FFF};
        end else begin
            packed_v = {1'b0, sign, mag[14:0]};
        end
        return packed_v;
    endfunction

    // Arithmetic on the latched operands: signed-magnitude add and one multiply step.
    always_comb begin
        sign_b_eff_s = b_q[15] ^ (op_q == OP_SUB);
        if (a_q[15] == sign_b_eff_s) begin
            addsub_mag_s  = {1'b0, a_q[14:0]} + {1'b0, b_q[14:0]};
            addsub_sign_s = a_q[15];
        end else if (a_q[14:0] >= b_q[14:0]) begin
            addsub_mag_s  = {1'b0, a_q[14:0]} - {1'b0, b_q[14:0]};
            addsub_sign_s = a_q[15];
        end else begin
            addsub_mag_s  = {1'b0, b_q[14:0]} - {1'b0, a_q[14:0]};
            addsub_sign_s = sign_b_eff_s;
        end
        addsub_pack_s = saturate(addsub_sign_s, {14'd0, addsub_mag_s});
        if (b_q[cnt_q] == 1'b1) begin
            partial_s = {15'd0, a_q[14:0]} << cnt_q;
        end else begin
            partial_s = 30'd0;
        end
        acc_next_s = acc_q + partial_s;
        mul_pack_s = saturate(a_q[15] ^ b_q[15], acc_next_s);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = opcode;
                    a_d    = operand_a;
                    b_d    = operand_b;
                    acc_d  = 30'd0;
                    cnt_d  = 4'd0;
                    ovf_d  = 1'b0;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    // Invalid codes share the one-cycle ADDSUB slot so all non-multiply ops finish alike.
                    if (opcode == OP_MUL) begin
                        state_d = MUL;
                    end else begin
                        state_d = ADDSUB;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ADDSUB: begin
                state_d = DONE;
                if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                    {ovf_d, result_d} = addsub_pack_s;
                    err_d = 1'b0;
                end else begin
                    result_d = 16'h0000;
                    ovf_d    = 1'b0;
                    err_d    = 1'b1;
                end
            end
            MUL: begin
                acc_d = acc_next_s;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd14) begin
                    state_d = DONE;
                    {ovf_d, result_d} = mul_pack_s;
                end else begin
                    state_d = MUL;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            acc_q    <= 30'd0;
            cnt_q    <= 4'd0;
            result_q <= 16'h0000;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = ovf_q;
    assign err      = err_q;

endmodule
